// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one tx serializer between N requesters.
// Defining TXARB_LOCK_EN enables a wormhole lock that holds a requester until its last flit.
`ifndef SIZE
`define SIZE 8
`endif

module tx_arbiter #(
  parameter int    N        = 5,
  parameter int    routerid = -1,
  parameter string port     = "unknown"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*`SIZE-1:0]   data_in,
  input  logic [N-1:0]         last,
  input  logic                 tx_active,
  input  logic                 tx_busy,
  output logic                 tx_req,
  output logic [`SIZE-1:0]     tx_data,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         ack
);
  // state     | meaning
  // IDLE      | no transfer; arbitrate when a request is pending and tx is not busy
  // ISSUE     | tx_req held with the winner's flit until tx_active is seen
  // WAIT_DONE | frame is serializing; grant released when tx_active drops
  localparam int PW     = $clog2(N);
  localparam bit LOG_EN = (routerid > -1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [N-1:0]    req_eff;
  logic [PW:0]     scan;
  logic [PW-1:0]   win;
  logic            win_vld;
  logic [PW-1:0]   win_next;
  logic [N-1:0]    win_oh;
  logic [`SIZE-1:0] win_flit;

`ifdef TXARB_LOCK_EN
  logic          locked;
  logic [PW-1:0] lock_id;

  always_comb begin
    req_eff = req;
    if (locked) req_eff = req & (N'(1) << lock_id);
  end
`else
  logic unused_last;

  assign unused_last = ^last;
  assign req_eff     = req;
`endif

  // First set request at or after ptr, wrapping modulo N.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    scan    = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(N)) scan = scan - (PW+1)'(N);
      if (!win_vld && req_eff[scan[PW-1:0]]) begin
        win     = scan[PW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  assign win_next = (win == PW'(N-1)) ? '0 : win + 1'b1;
  assign win_oh   = N'(1) << win;
  assign win_flit = data_in[win*`SIZE +: `SIZE];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      tx_req  <= 1'b0;
      tx_data <= '0;
      grant   <= '0;
      ack     <= '0;
`ifdef TXARB_LOCK_EN
      locked  <= 1'b0;
      lock_id <= '0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (win_vld && !tx_busy) begin
            grant   <= win_oh;
            ack     <= win_oh;
            tx_data <= win_flit;
            tx_req  <= 1'b1;
            state   <= ISSUE;
`ifdef TXARB_LOCK_EN
            // ptr stays put while a packet is in flight so the owner resumes first.
            if (last[win]) begin
              ptr    <= win_next;
              locked <= 1'b0;
            end else begin
              locked  <= 1'b1;
              lock_id <= win;
            end
`else
            ptr <= win_next;
`endif
          end
        end
        ISSUE: begin
          if (tx_active) begin
            tx_req <= 1'b0;
            state  <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_active) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (LOG_EN && reset && state == IDLE && win_vld && !tx_busy)
      $display("%0t router %0d port %s: grant %0d flit %h",
               $time, routerid, port, win, win_flit);
  end
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: vector table, corner sequences and randomized queues vs a model.
`timescale 1ns/1ps
`ifndef SIZE
`define SIZE 8
`endif

module tb_tx_arbiter;
  localparam int N     = 5;
  localparam int W     = `SIZE;
  localparam int FRAME = W + 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   last;
  logic           tx_active;
  logic           channel_busy;
  logic           tx_busy;
  logic           tx_req;
  logic [W-1:0]   tx_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;

  int total = 0;
  int bad   = 0;
  int tx_cnt;
  logic [W-1:0] rx_q[$];

  typedef struct { logic [N-1:0] req; logic [W-1:0] flit; int win; } vec_t;
  typedef struct { logic [W-1:0] d; logic l; } flit_t;

  vec_t  tbl[12];
  flit_t q[N][$];
  int    order[$];

  assign tx_busy = tx_active | channel_busy;
  always #5 clk = ~clk;

  tx_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .last(last),
    .tx_active(tx_active), .tx_busy(tx_busy), .tx_req(tx_req), .tx_data(tx_data),
    .grant(grant), .ack(ack)
  );

  // tx model: takes the parallel flit when idle and the channel is free, stays active FRAME cycles.
  always @(posedge clk) begin
    if (!reset) begin
      tx_active <= 1'b0;
      tx_cnt    <= 0;
    end else if (!tx_active) begin
      if (tx_req && !channel_busy) begin
        tx_active <= 1'b1;
        tx_cnt    <= FRAME - 1;
        rx_q.push_back(tx_data);
      end
    end else if (tx_cnt == 0) begin
      tx_active <= 1'b0;
    end else begin
      tx_cnt <= tx_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    reset        = 1'b0;
    req          = '0;
    channel_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
  endtask

  task automatic wait_grant_release(input string tag, input logic [N-1:0] g);
    int t;
    t = 0;
    while (tx_active !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    t = 0;
    while (tx_active !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    check({tag, " grant held"}, grant, g);
    @(negedge clk);
    check({tag, " grant clear"}, grant, 0);
    check({tag, " tx_req idle"}, tx_req, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    req = v.req;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = (i == v.win) ? v.flit : ~v.flit;
    t = 0;
    do begin @(negedge clk); t++; end while (ack == '0 && t < 50);
    check("vec ack", ack, N'(1) << v.win);
    check("vec grant", grant, N'(1) << v.win);
    check("vec tx_req", tx_req, 1);
    check("vec tx_data", tx_data, v.flit);
    @(negedge clk);
    check("vec ack pulse", ack, 0);
    req = '0;
    wait_grant_release("vec", N'(1) << v.win);
    if (rx_q.size() == 1) check("vec rx flit", rx_q.pop_front(), v.flit);
    else check("vec rx count", rx_q.size(), 1);
    rx_q.delete();
  endtask

  task automatic run_queues(input int cycles);
    int m_ptr, m_lock, since_ack, c, w, a, i;
    bit m_locked, pending, busy_prev;
    logic [N-1:0] req_prev, cand;
    logic [W-1:0] exp_q[$];
    flit_t f;
    m_ptr = 0; m_lock = 0; m_locked = 0; since_ack = 100; c = 0;
    order.delete();
    for (int k = 0; k < N; k++) begin
      req[k]          = q[k].size() > 0;
      data_in[k*W +: W] = req[k] ? q[k][0].d : W'($urandom);
      last[k]         = req[k] ? q[k][0].l : 1'b0;
    end
    req_prev  = req;
    busy_prev = tx_active | channel_busy;
    forever begin
      @(negedge clk);
      c++;
      if (ack != '0) begin
        cand = m_locked ? (req_prev & (N'(1) << m_lock)) : req_prev;
        w = rr_pick(cand, m_ptr);
        a = idx_of(ack);
        order.push_back(a);
        check("rq ack", ack, (w < 0) ? 0 : (N'(1) << w));
        check("rq grant", grant, ack);
        check("rq tx_busy at arbitration", busy_prev, 0);
        check("rq ack spacing ok", since_ack + 1 >= FRAME + 2, 1);
        since_ack = 0;
        if (w >= 0 && q[w].size() > 0) begin
          f = q[w].pop_front();
          check("rq tx_data", tx_data, f.d);
          exp_q.push_back(f.d);
`ifdef TXARB_LOCK_EN
          if (!f.l) begin
            m_locked = 1'b1;
            m_lock   = w;
          end else begin
            m_locked = 1'b0;
            m_ptr    = (w + 1) % N;
          end
`else
          m_ptr = (w + 1) % N;
`endif
        end
      end else begin
        since_ack++;
      end

      while (rx_q.size() > 0) begin
        if (exp_q.size() > 0) check("rq rx flit", rx_q.pop_front(), exp_q.pop_front());
        else begin
          check("rq rx extra", rx_q.size(), 0);
          rx_q.delete();
        end
      end

      pending = (grant != '0) || (ack != '0);
      for (int k = 0; k < N; k++) if (q[k].size() > 0) pending = 1'b1;
      if (c >= cycles && !pending) break;
      if (pending && since_ack > 300) begin
        total++; bad++;
        $display("FAIL rq progress: %0d cycles without ack, pending work", since_ack);
        break;
      end

      if (c < cycles) begin
        if ($urandom_range(0, 2) == 0) begin
          i = $urandom_range(0, N-1);
          if (q[i].size() < 4) q[i].push_back('{W'($urandom), 1'($urandom_range(0, 1))});
        end
        channel_busy = ($urandom_range(0, 7) == 0);
      end else begin
        channel_busy = 1'b0;
      end
      if (m_locked && q[m_lock].size() == 0) q[m_lock].push_back('{W'($urandom), 1'b1});

      for (int k = 0; k < N; k++) begin
        req[k]            = q[k].size() > 0;
        data_in[k*W +: W] = req[k] ? q[k][0].d : W'($urandom);
        last[k]           = req[k] ? q[k][0].l : 1'($urandom_range(0, 1));
      end
      req_prev  = req;
      busy_prev = tx_active | channel_busy;
    end
    check("rq drained", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef TXARB_LOCK_EN
    int exp_order[5] = '{1, 1, 1, 3, 3};
`else
    int exp_order[5] = '{1, 3, 1, 3, 1};
`endif
    int t;
    tbl[0]  = '{5'b11111, 8'h11, 0};
    tbl[1]  = '{5'b00100, 8'hA5, 2};
    tbl[2]  = '{5'b11111, 8'h33, 3};
    tbl[3]  = '{5'b11111, 8'h44, 4};
    tbl[4]  = '{5'b11111, 8'h50, 0};
    tbl[5]  = '{5'b11111, 8'h61, 1};
    tbl[6]  = '{5'b11111, 8'h72, 2};
    tbl[7]  = '{5'b11111, 8'h83, 3};
    tbl[8]  = '{5'b01001, 8'h90, 0};
    tbl[9]  = '{5'b01001, 8'h93, 3};
    tbl[10] = '{5'b10000, 8'hC4, 4};
    tbl[11] = '{5'b00011, 8'hD0, 0};

    reset        = 1'b0;
    req          = '1;
    last         = '1;
    data_in      = '0;
    channel_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset tx_req", tx_req, 0);
      check("reset grant", grant, 0);
      check("reset ack", ack, 0);
    end
    reset = 1'b1;

    for (int v = 0; v < 12; v++) run_vec(tbl[v]);

    // Channel stall: request pending but tx busy for 20 cycles.
    channel_busy = 1'b1;
    req          = 5'b00001;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = (i == 0) ? 8'h3C : 8'hC3;
    repeat (20) begin
      @(negedge clk);
      check("stall quiet", {tx_req, ack}, 0);
    end
    channel_busy = 1'b0;
    @(negedge clk);
    check("stall release ack", ack, 5'b00001);
    check("stall release tx_data", tx_data, 8'h3C);
    req = '0;
    wait_grant_release("stall", 5'b00001);
    if (rx_q.size() == 1) check("stall rx flit", rx_q.pop_front(), 8'h3C);
    else check("stall rx count", rx_q.size(), 1);

    // Packet of three flits from requester 1 competing with requester 3.
    do_reset();
    q[1].push_back('{8'h11, 1'b0});
    q[1].push_back('{8'h22, 1'b0});
    q[1].push_back('{8'h33, 1'b1});
    q[3].push_back('{8'h44, 1'b1});
    q[3].push_back('{8'h55, 1'b1});
    run_queues(0);
    check("lock order count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      check("lock order", (i < order.size()) ? order[i] : -1, exp_order[i]);

    do_reset();
    for (int k = 0; k < N; k++) q[k].delete();
    run_queues(3000);

    t = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
